// File: rtl/req_arbiter_n.sv
// req_arbiter_n: registered N-way request/grant arbiter with fixed-priority or round-robin mode and hold timeout
module req_arbiter_n #(
  parameter int N_REQ    = 3,
  parameter int HOLD_MAX = 0,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id
);
  localparam int HW = HOLD_MAX < 1 ? 1 : $clog2(HOLD_MAX + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
  logic [HW-1:0]     hold;
  logic [N_REQ-1:0]  cand;
  logic              found;
  logic              timeout;
  logic              owner_req;
  logic              bad;
  // Pick the winner: scan from the highest slot down so the first slot in scan order is written last
  always_comb begin
    owner_req = |(req & grant);
    timeout   = mode && HOLD_MAX != 0 && state == GRANT && int'(hold) == HOLD_MAX - 1 && owner_req;
    cand      = timeout ? req & ~grant : req;
    found     = 1'b0;
    win       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[mode ? (int'(ptr) + i) % N_REQ : i]) begin
        found = 1'b1;
        win   = ID_W'(mode ? (int'(ptr) + i) % N_REQ : i);
      end
    end
    bad = grant_valid != |grant || int'(grant_id) >= N_REQ ||
          (state == IDLE  ? (grant != '0 || grant_id != '0) :
           state == GRANT ? grant != (N_REQ'(1) << grant_id) : 1'b1);
  end
  // Grant FSM: hold the owner until it releases or times out, otherwise re-arbitrate without a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= '0;
      hold        <= '0;
    end else if (bad) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      hold        <= '0;
    end else if (state == IDLE || !owner_req || timeout) begin
      if (found) begin
        state       <= GRANT;
        grant       <= N_REQ'(1) << win;
        grant_valid <= 1'b1;
        grant_id    <= win;
        hold        <= '0;
        if (mode) ptr <= int'(win) == N_REQ - 1 ? '0 : win + 1'b1;
      end else if (timeout) begin
        hold <= '0;
      end else begin
        state       <= IDLE;
        grant       <= '0;
        grant_valid <= 1'b0;
        grant_id    <= '0;
        hold        <= '0;
      end
    end else if (int'(hold) < HOLD_MAX - 1) begin
      hold <= hold + 1'b1;
    end
  end
endmodule

// File: tb/tb_req_arbiter_n.sv
// tb_req_arbiter_n: randomized and directed check of req_arbiter_n against a behavioural model
module tb_req_arbiter_n;
  localparam int N = 3;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] g0, g1;
  logic         v0, v1;
  logic [1:0]   id0, id1;
  int n_cmp = 0;
  int n_bad = 0;
  int own[2];
  int ptr[2];
  int cnt[2];
  int hm[2] = '{0, 4};

  always #5 clk = ~clk;

  req_arbiter_n #(.N_REQ(N), .HOLD_MAX(0)) u0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req),
    .grant(g0), .grant_valid(v0), .grant_id(id0)
  );
  req_arbiter_n #(.N_REQ(N), .HOLD_MAX(4)) u1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req),
    .grant(g1), .grant_valid(v1), .grant_id(id1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int r, input int m, input int p);
    for (int k = 0; k < N; k++) begin
      int s;
      s = m != 0 ? (p + k) % N : k;
      if (r[s]) return s;
    end
    return -1;
  endfunction

  task automatic take(input int i, input int w);
    cnt[i] = 0;
    own[i] = w;
    if (w >= 0 && mode) ptr[i] = (w + 1) % N;
  endtask

  task automatic step(input int i);
    int r;
    r = int'(req);
    if (!rst_n) begin
      own[i] = -1;
      ptr[i] = 0;
      cnt[i] = 0;
    end else if (own[i] < 0 || !r[own[i]]) begin
      take(i, pick(r, int'(mode), ptr[i]));
    end else if (mode && hm[i] != 0 && cnt[i] == hm[i] - 1) begin
      int w;
      w = pick(r & ~(1 << own[i]), 1, ptr[i]);
      if (w < 0) cnt[i] = 0;
      else take(i, w);
    end else if (cnt[i] < hm[i] - 1) begin
      cnt[i]++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    step(0);
    step(1);
    #1;
    chk("grant0", 32'(g0), own[0] < 0 ? 0 : 1 << own[0]);
    chk("valid0", 32'(v0), 32'(own[0] >= 0));
    chk("id0", 32'(id0), own[0] < 0 ? 0 : own[0]);
    chk("grant1", 32'(g1), own[1] < 0 ? 0 : 1 << own[1]);
    chk("valid1", 32'(v1), 32'(own[1] >= 0));
    chk("id1", 32'(id1), own[1] < 0 ? 0 : own[1]);
  endtask

  initial begin
    rst_n = 1'b0; req = 3'b111; mode = 1'b0;
    cyc(); cyc();
    chk("rst_grant", 32'(g0), 0);
    chk("rst_valid", 32'(v0), 0);
    rst_n = 1'b1;
    cyc();
    chk("rst_first", 32'(g0), 1);
    req = 3'b000; cyc();
    req = 3'b110; cyc();
    chk("fix_110", 32'(g0), 2);
    req = 3'b111; cyc();
    chk("fix_nopre", 32'(g0), 2);
    req = 3'b101; cyc();
    chk("fix_rel", 32'(g0), 1);

    rst_n = 1'b0; cyc();
    rst_n = 1'b1; mode = 1'b1; req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rr_owner", 32'(id0), k % 3);
      req = 3'b111;
      cyc();
      req = 3'b111 & ~(3'b001 << (k % 3));
    end

    rst_n = 1'b0; cyc();
    rst_n = 1'b1; mode = 1'b1; req = 3'b011;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk("rr_tmo", 32'(g1), ((k / 4) % 2) != 0 ? 2 : 1);
    end

    req = 3'b100;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k > 0) chk("lone", 32'(g1), 4);
    end

    for (int m = 1; m >= 0; m--) begin
      rst_n = 1'b0; cyc();
      rst_n = 1'b1; mode = m[0]; req = 3'b100;
      cyc(); cyc();
      chk("mid_own", 32'(g0), 4);
      rst_n = 1'b0; cyc();
      chk("mid_rst", 32'(g0), 0);
      rst_n = 1'b1; req = 3'b110;
      cyc();
      chk("mid_after", 32'(g0), 2);
    end

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      rst_n = $urandom_range(0, 59) != 0;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
